// File: rtl/noc_pkg.sv
// Shared NoC types: flit encoding, router sizing defaults and allocator state.
package noc_pkg;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_HEAD = 2'd1,
    TYPE_DATA = 2'd2,
    TYPE_TAIL = 2'd3
  } flit_type_t;

  localparam int PORT_N         = 5;
  localparam int CREDIT_MAX_DEF = 4;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter int N = 5,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end

endmodule

// File: rtl/noc_outport_alloc.sv
// Output-port allocator: round-robin on head flits, packet lock until tail,
// downstream credit tracking and sticky protocol error.
//
// state        | meaning
// ALLOC_IDLE   | port free; heads compete round-robin from rr+1
// ALLOC_LOCKED | port owned by owner_q until its tail flit fires
module noc_outport_alloc #(
  parameter int PORT_N     = noc_pkg::PORT_N,
  parameter int CREDIT_MAX = noc_pkg::CREDIT_MAX_DEF,
  parameter int CW         = $clog2(CREDIT_MAX + 1),
  parameter int SW         = $clog2(PORT_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORT_N-1:0]      req_i,
  input  logic [PORT_N-1:0][1:0] ftype_i,
  input  logic                   credit_ret_i,
  output logic [PORT_N-1:0]      grant_o,
  output logic                   fire_o,
  output logic [SW-1:0]          sel_o,
  output logic [CW-1:0]          credit_o,
  output logic                   busy_o,
  output logic                   err_o
);

  import noc_pkg::*;

  alloc_state_t      state_q, state_d;
  logic [SW-1:0]     owner_q, owner_d;
  logic [SW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     credit_q;
  logic              err_q;

  logic [PORT_N-1:0] eff, cand, pick_gnt, owner_onehot;
  logic [SW-1:0]     pick_idx;
  logic              has_credit, credit_full;
  flit_type_t        owner_type;
  logic              err_set;

  always_comb begin
    eff  = '0;
    cand = '0;
    for (int i = 0; i < PORT_N; i++) begin
      eff[i]  = req_i[i] && (flit_type_t'(ftype_i[i]) != TYPE_NONE);
      cand[i] = eff[i] && (flit_type_t'(ftype_i[i]) == TYPE_HEAD);
    end
  end

  rr_pick #(.N(PORT_N), .W(SW)) u_rr_pick (
    .req   (cand),
    .ptr   (rr_q),
    .grant (pick_gnt),
    .idx   (pick_idx)
  );

  assign has_credit   = (credit_q != '0);
  assign credit_full  = (credit_q == CW'(CREDIT_MAX));
  assign owner_type   = flit_type_t'(ftype_i[owner_q]);
  assign owner_onehot = {{(PORT_N-1){1'b0}}, 1'b1} << owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALLOC_IDLE;
      owner_q <= '0;
      rr_q    <= SW'(PORT_N - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      ALLOC_IDLE: begin
        if (fire_o) begin
          owner_d = pick_idx;
          state_d = ALLOC_LOCKED;
        end
      end
      ALLOC_LOCKED: begin
        if (fire_o && owner_type == TYPE_TAIL) begin
          state_d = ALLOC_IDLE;
          rr_d    = owner_q;
        end
      end
      default: state_d = ALLOC_IDLE;
    endcase
  end

  // sel_o follows the winner during the IDLE grant so the crossbar switches with the head
  always_comb begin
    grant_o = '0;
    sel_o   = owner_q;
    case (state_q)
      ALLOC_IDLE: begin
        if (has_credit && (|cand)) begin
          grant_o = pick_gnt;
          sel_o   = pick_idx;
        end
      end
      ALLOC_LOCKED: begin
        if (req_i[owner_q] && has_credit) grant_o = owner_onehot;
      end
      default: grant_o = '0;
    endcase
  end

  assign fire_o   = |grant_o;
  assign busy_o   = (state_q == ALLOC_LOCKED);
  assign credit_o = credit_q;
  assign err_o    = err_q;

  always_comb begin
    err_set = 1'b0;
    if (state_q == ALLOC_IDLE && (|(eff & ~cand))) err_set = 1'b1;
    if (state_q == ALLOC_LOCKED && req_i[owner_q] && owner_type == TYPE_HEAD) err_set = 1'b1;
    if (credit_ret_i && !fire_o && credit_full) err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(CREDIT_MAX);
      err_q    <= 1'b0;
    end else begin
      case ({fire_o, credit_ret_i})
        2'b10:   credit_q <= credit_q - 1'b1;
        2'b01:   if (!credit_full) credit_q <= credit_q + 1'b1;
        default: credit_q <= credit_q;
      endcase
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule
